// File: rtl/apb_regfile_slave.sv
// APB completer backed by a bank of DEPTH word registers.
// Programmable wait states; out-of-range or misaligned accesses return pslverr.
module apb_regfile_slave #(
  parameter int DATA        = 32,
  parameter int ADDR        = 32,
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic            pclk,
  input  logic            preset,
  input  logic            psel,
  input  logic            penable,
  input  logic            pwrite,
  input  logic [ADDR-1:0] paddr,
  input  logic [DATA-1:0] pwdata,
  output logic            pready,
  output logic [DATA-1:0] prdata,
  output logic            pslverr
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [3:0] WC = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t          r_state;
  logic [3:0]      r_cnt;
  logic [DATA-1:0] r_mem [DEPTH];

  logic [IW-1:0]   w_idx;
  logic            w_valid;
  logic [DATA-1:0] w_rdata;

  assign w_idx   = paddr[IW+1:2];
  assign w_valid = (paddr[1:0] == 2'b00) &&
                   (paddr[ADDR-1:IW+2] == '0);
  assign w_rdata = (w_valid && !pwrite) ? r_mem[w_idx] : '0;

  // Response outputs are loaded on the edge that enters RESP,
  // so they are visible for exactly the RESP cycle.
  always_ff @(posedge pclk) begin
    if (preset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      pready  <= 1'b0;
      prdata  <= '0;
      pslverr <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      pready  <= 1'b0;
      prdata  <= '0;
      pslverr <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (psel && !penable) begin
            r_cnt <= WC;
            if (WC == 4'd0) begin
              r_state <= S_RESP;
              pready  <= 1'b1;
              prdata  <= w_rdata;
              pslverr <= !w_valid;
            end else begin
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (!psel) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else if (penable) begin
            if (r_cnt <= 4'd1) begin
              r_state <= S_RESP;
              r_cnt   <= '0;
              pready  <= 1'b1;
              prdata  <= w_rdata;
              pslverr <= !w_valid;
            end else begin
              r_cnt <= r_cnt - 4'd1;
            end
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
          if (psel && pwrite && w_valid) begin
            r_mem[w_idx] <= pwdata;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Directed bench for apb_regfile_slave: several instances with
// different wait-state counts share one APB bus.
module tb_apb_regfile_slave;

  logic        pclk = 1'b0;
  logic        preset = 1'b1;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [31:0] paddr = '0;
  logic [31:0] pwdata = '0;

  logic [4:0]  rdy;
  logic [31:0] prd [5];
  logic [4:0]  err;

  int ntests = 0;
  int nfail = 0;

  always #5 pclk = ~pclk;

  // k: 0 -> W0, 1 -> W1, 2 -> W3, 3 -> W15, 4 -> W4
  apb_regfile_slave #(.WAIT_CYCLES(0)) u_w0 (
    .pclk(pclk), .preset(preset), .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pready(rdy[0]), .prdata(prd[0]), .pslverr(err[0]));
  apb_regfile_slave #(.WAIT_CYCLES(1)) u_w1 (
    .pclk(pclk), .preset(preset), .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pready(rdy[1]), .prdata(prd[1]), .pslverr(err[1]));
  apb_regfile_slave #(.WAIT_CYCLES(3)) u_w3 (
    .pclk(pclk), .preset(preset), .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pready(rdy[2]), .prdata(prd[2]), .pslverr(err[2]));
  apb_regfile_slave #(.WAIT_CYCLES(15)) u_w15 (
    .pclk(pclk), .preset(preset), .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pready(rdy[3]), .prdata(prd[3]), .pslverr(err[3]));
  apb_regfile_slave #(.WAIT_CYCLES(4)) u_w4 (
    .pclk(pclk), .preset(preset), .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pready(rdy[4]), .prdata(prd[4]), .pslverr(err[4]));

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rst();
    @(posedge pclk); #1;
    preset = 1'b1; psel = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
    preset = 1'b0;
    @(negedge pclk);
  endtask

  // Full transfer; lat = cycles from setup to pready (-1 if none).
  task automatic xfer(input int k, input logic wr,
                      input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd_o, output logic er_o,
                      output int lat);
    lat = -1; rd_o = '0; er_o = 1'b0;
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0;
    pwrite = wr; paddr = a; pwdata = d;
    @(posedge pclk); #1;
    penable = 1'b1;
    for (int j = 1; j <= 40; j++) begin
      @(negedge pclk);
      if (rdy[k]) begin
        lat = j; rd_o = prd[k]; er_o = err[k];
        break;
      end
    end
  endtask

  task automatic idle();
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
    @(negedge pclk);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  int          first [4];
  int          cnt [4];
  int          seen;
  int          ws [4] = '{0, 1, 3, 15};

  initial begin
    rst();
    chk("rst_pready", 32'(rdy[1]), 0);
    chk("rst_prdata", prd[1], 0);
    chk("rst_pslverr", 32'(err[1]), 0);

    // write / read-back, W=1
    xfer(1, 1'b1, 32'h08, 32'hDEADBEEF, rd, er, lat);
    chk("wr_lat", 32'(lat), 2);
    chk("wr_err", 32'(er), 0);
    chk("wr_prdata", rd, 0);
    xfer(1, 1'b0, 32'h08, 32'h0, rd, er, lat);
    chk("rd_lat", 32'(lat), 2);
    chk("rd_err", 32'(er), 0);
    chk("rd_data", rd, 32'hDEADBEEF);
    @(negedge pclk);
    chk("post_rd_pready", 32'(rdy[1]), 0);
    chk("post_rd_prdata", prd[1], 0);
    idle();

    // error accesses
    rst();
    xfer(1, 1'b1, 32'h40, 32'h1234, rd, er, lat);
    chk("oor_wr_lat", 32'(lat), 2);
    chk("oor_wr_err", 32'(er), 1);
    xfer(1, 1'b1, 32'h05, 32'h1234, rd, er, lat);
    chk("mis_wr_err", 32'(er), 1);
    xfer(1, 1'b0, 32'h40, 32'h0, rd, er, lat);
    chk("oor_rd_err", 32'(er), 1);
    chk("oor_rd_data", rd, 0);
    xfer(1, 1'b0, 32'h05, 32'h0, rd, er, lat);
    chk("mis_rd_err", 32'(er), 1);
    chk("mis_rd_data", rd, 0);
    for (int i = 0; i < 16; i++) begin
      xfer(1, 1'b0, 32'(i * 4), 32'h0, rd, er, lat);
      chk($sformatf("err_reg%0d", i), rd, 0);
    end
    idle();

    // back-to-back with psel held high
    rst();
    xfer(1, 1'b1, 32'h00, 32'h1, rd, er, lat);
    chk("b2b_w0_lat", 32'(lat), 2);
    xfer(1, 1'b1, 32'h04, 32'h2, rd, er, lat);
    chk("b2b_w1_lat", 32'(lat), 2);
    chk("b2b_w1_err", 32'(er), 0);
    xfer(1, 1'b0, 32'h00, 32'h0, rd, er, lat);
    chk("b2b_r0_lat", 32'(lat), 2);
    chk("b2b_r0", rd, 32'h1);
    xfer(1, 1'b0, 32'h04, 32'h0, rd, er, lat);
    chk("b2b_r1_lat", 32'(lat), 2);
    chk("b2b_r1", rd, 32'h2);
    // penable without setup must be ignored
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 32'h0;
    seen = 0;
    for (int j = 0; j < 5; j++) begin
      @(negedge pclk);
      if (rdy[1]) seen++;
    end
    chk("noset_pready", 32'(seen), 0);
    idle();

    // reset in the middle of a transfer
    rst();
    xfer(1, 1'b1, 32'h0C, 32'hCAFE, rd, er, lat);
    chk("pre_rst_wr_lat", 32'(lat), 2);
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 32'h0C; pwdata = 32'hBEEF;
    @(posedge pclk); #1;
    penable = 1'b1; preset = 1'b1;
    @(negedge pclk);
    chk("mid_rst_pready", 32'(rdy[1]), 0);
    chk("mid_rst_prdata", prd[1], 0);
    chk("mid_rst_pslverr", 32'(err[1]), 0);
    @(posedge pclk); #1;
    preset = 1'b0; psel = 1'b0; penable = 1'b0;
    xfer(1, 1'b0, 32'h0C, 32'h0, rd, er, lat);
    chk("mid_rst_cleared", rd, 0);
    xfer(1, 1'b1, 32'h0C, 32'h12345678, rd, er, lat);
    xfer(1, 1'b0, 32'h0C, 32'h0, rd, er, lat);
    chk("mid_rst_rdback", rd, 32'h12345678);
    idle();

    // wait-state sweep across instances
    rst();
    for (int k = 0; k < 4; k++) begin
      first[k] = -1; cnt[k] = 0;
    end
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h10;
    @(posedge pclk); #1;
    penable = 1'b1;
    for (int j = 1; j <= 20; j++) begin
      @(negedge pclk);
      for (int k = 0; k < 4; k++) begin
        if (rdy[k]) begin
          if (first[k] < 0) first[k] = j;
          cnt[k]++;
        end
      end
    end
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("sweep_lat_w%0d", ws[k]), 32'(first[k]),
          32'(ws[k] + 1));
      chk($sformatf("sweep_cnt_w%0d", ws[k]), 32'(cnt[k]), 1);
    end
    idle();

    // abort, W=4: psel drops in the 2nd access cycle
    rst();
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 32'h00; pwdata = 32'hA5A5A5A5;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
    seen = 0;
    for (int j = 0; j < 8; j++) begin
      @(negedge pclk);
      if (rdy[4]) seen++;
    end
    chk("abort_pready", 32'(seen), 0);
    xfer(4, 1'b0, 32'h00, 32'h0, rd, er, lat);
    chk("abort_next_lat", 32'(lat), 5);
    chk("abort_reg0", rd, 0);
    chk("abort_next_err", 32'(er), 0);
    idle();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
